// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the gate self-test block.
// Holds the tester state enum, the pattern LFSR seed/taps, the vector-index
// width and the LFSR step helper used when GATE_TESTER_LFSR_EN is defined.
package gate_test_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0]  LFSR_SEED = 8'h01;
    // Tap mask in polynomial order: bit 7 = x^8 ... bit 3 = x^4.
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam int unsigned VEC_W     = 16;

    // One right-shift Fibonacci step; polynomial term x^(8-k) taps register bit k,
    // so mask bit i selects register bit 7-i. New bit enters at the top.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (LFSR_TAPS[i]) begin
                fb = fb ^ s[7-i];
            end else begin
                fb = fb;
            end
        end
        return {fb, s[7:1]};
    endfunction

endpackage

// File: rtl/gate_tester_if.sv
// Control/status and gate-link signals of the gate tester.
// master = tester side, slave = environment (controller plus gate under test).
interface gate_tester_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic                              start;
    logic                              resp;
    logic                              stim;
    logic                              busy;
    logic                              done;
    logic                              pass;
    logic [CNT_W-1:0]                  err_count;
    logic [gate_test_pkg::VEC_W-1:0]   vec_idx;

    modport master (
        input  start, resp,
        output stim, busy, done, pass, err_count, vec_idx
    );

    modport slave (
        output start, resp,
        input  stim, busy, done, pass, err_count, vec_idx
    );
endinterface

// File: rtl/gate_tester_stim_gen.sv
// Stimulus pattern source for the gate tester.
// Default build: alternating 0,1,0,1,... that tracks vec_idx[0].
// With GATE_TESTER_LFSR_EN: bit 0 of an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
module stim_gen import gate_test_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic reseed,
    input  logic advance,
    output logic bit_out
);

`ifdef GATE_TESTER_LFSR_EN
    logic [7:0] r_lfsr;

    // LFSR state: back to seed on reset or run start, one step per vector advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (reseed) begin
            r_lfsr <= LFSR_SEED;
        end else if (advance) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

    assign bit_out = r_lfsr[0];
`else
    logic r_alt;

    // Alternating bit: cleared on reset or run start, toggles per vector advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alt <= 1'b0;
        end else if (reseed) begin
            r_alt <= 1'b0;
        end else if (advance) begin
            r_alt <= ~r_alt;
        end else begin
            r_alt <= r_alt;
        end
    end

    assign bit_out = r_alt;
`endif

endmodule

// File: rtl/gate_tester.sv
// Self-test driver/checker for a single-bit inverting gate.
// Drives stim, waits SETTLE_CYCLES, samples resp against ~stim, counts
// mismatches (saturating) and reports pass/done. Pattern source selected by
// the GATE_TESTER_LFSR_EN macro inside stim_gen.
module gate_tester import gate_test_pkg::*; #(
    parameter int unsigned NUM_VECTORS   = 16,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    gate_tester_if.master gt
);

    localparam int unsigned        SCNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0]  SETTLE_LOAD = SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SCNT_W-1:0]  SCNT_ZERO   = {SCNT_W{1'b0}};
    localparam logic [SCNT_W-1:0]  SCNT_ONE    = SCNT_W'(1);
    localparam logic [VEC_W-1:0]   LAST_IDX    = VEC_W'(NUM_VECTORS - 1);
    localparam logic [VEC_W-1:0]   IDX_ZERO    = {VEC_W{1'b0}};
    localparam logic [VEC_W-1:0]   IDX_ONE     = VEC_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

    state_t             r_state, w_state;
    logic [SCNT_W-1:0]  r_cnt,   w_cnt;
    logic               r_stim,  w_stim;
    logic               r_busy,  w_busy;
    logic               r_done,  w_done;
    logic               r_pass,  w_pass;
    logic [CNT_W-1:0]   r_err,   w_err;
    logic [VEC_W-1:0]   r_idx,   w_idx;
    logic               w_reseed;
    logic               w_advance;
    logic               w_pat;
    logic               w_expect;

    stim_gen u_stim_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .reseed  (w_reseed),
        .advance (w_advance),
        .bit_out (w_pat)
    );

    assign w_expect = ~r_stim;

    // Next-state and next-output logic; status flags derive from the next state
    // so busy/done/pass are registered yet line up with the state they describe
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_stim    = r_stim;
        w_err     = r_err;
        w_idx     = r_idx;
        w_pass    = r_pass;
        w_reseed  = 1'b0;
        w_advance = 1'b0;

        case (r_state)
            IDLE: begin
                if (gt.start) begin
                    w_state  = DRIVE;
                    w_err    = CNT_ZERO;
                    w_idx    = IDX_ZERO;
                    w_pass   = 1'b0;
                    w_reseed = 1'b1;
                end else begin
                    w_state = IDLE;
                end
            end
            DRIVE: begin
                w_stim  = w_pat;
                w_cnt   = SETTLE_LOAD;
                w_state = SETTLE;
            end
            SETTLE: begin
                if (r_cnt == SCNT_ZERO) begin
                    w_state = SAMPLE;
                end else begin
                    w_cnt = r_cnt - SCNT_ONE;
                end
            end
            SAMPLE: begin
                if ((gt.resp != w_expect) && (r_err != CNT_MAX)) begin
                    w_err = r_err + CNT_ONE;
                end else begin
                    w_err = r_err;
                end
                if (r_idx == LAST_IDX) begin
                    w_state = DONE;
                end else begin
                    w_idx     = r_idx + IDX_ONE;
                    w_advance = 1'b1;
                    w_state   = DRIVE;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        w_busy = (w_state == DRIVE) || (w_state == SETTLE) || (w_state == SAMPLE);
        w_done = (w_state == DONE);
        // Verdict uses the count after the final compare (w_err).
        w_pass = (w_state == DONE) ? (w_err == CNT_ZERO) : w_pass;
    end

    // State and output registers; asynchronous reset aborts any run in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= SCNT_ZERO;
            r_stim  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= CNT_ZERO;
            r_idx   <= IDX_ZERO;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_stim  <= w_stim;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_err   <= w_err;
            r_idx   <= w_idx;
        end
    end

    assign gt.stim      = r_stim;
    assign gt.busy      = r_busy;
    assign gt.done      = r_done;
    assign gt.pass      = r_pass;
    assign gt.err_count = r_err;
    assign gt.vec_idx   = r_idx;

endmodule
